// File: rtl/biu8086_pkg.sv
// biu8086_pkg: bus states, lane constants and split helper
// shared by the 8086/8088 bus interface unit.
package biu8086_pkg;

    typedef enum logic [2:0] {
        ST_TI,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_TW,
        ST_T4,
        ST_TH
    } bus_state_e;

    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;

    localparam logic BHE_ON  = 1'b0;
    localparam logic BHE_OFF = 1'b1;

    function automatic logic split_needed(
        input logic a0,
        input logic word,
        input int   data_w
    );
        return word && ((data_w == 8) || a0);
    endfunction

    // Lanes carrying the byte(s) of one bus cycle
    function automatic logic [1:0] lane_sel(
        input logic a0,
        input logic full,
        input int   data_w
    );
        if (data_w == 8) return LANE_LO;
        if (full)        return LANE_BOTH;
        return a0 ? LANE_HI : LANE_LO;
    endfunction

endpackage

// File: rtl/biu8086_wait_timer.sv
// biu8086_wait_timer: saturating Tw counter that flags the
// last allowed wait state of a bus cycle.
module biu8086_wait_timer #(
    parameter int WAIT_MAX = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_tw,
    output logic o_timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_tw && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_timeout = i_tw && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/biu8086_bus.sv
// biu8086_bus: 8086/8088 bus interface unit, T1-T4 cycle sequencer.
// Define BIU_HOLD_EN to add HOLD/HLDA bus arbitration.
module biu8086_bus
    import biu8086_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int WAIT_MAX = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     req_wr,
    input  logic                     req_io,
    input  logic                     req_word,
    input  logic [15:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [15:0]              rsp_rdata,
    output logic                     rsp_err,
    input  logic                     ready,
    input  logic [DATA_W-1:0]        ad_in,
    output logic [DATA_W-1:0]        ad_out,
    output logic                     ad_oe,
    output logic [ADDR_W-DATA_W-1:0] a_hi,
    output logic                     ale,
    output logic                     m_ioN,
    output logic                     dt_rN,
    output logic                     denN,
    output logic                     rdN,
    output logic                     wrN,
`ifdef BIU_HOLD_EN
    input  logic                     hold,
    output logic                     hlda,
`endif
    output logic                     bheN
);

    bus_state_e r_state, w_n_state;
    logic [ADDR_W-1:0] r_addr, w_n_addr;
    logic [15:0] r_wdata, w_n_wdata;
    logic r_wr, w_n_wr, r_io, w_n_io, r_word, w_n_word;
    logic r_split, w_n_split, r_second, w_n_second;
    logic [7:0] r_lo, w_n_lo;

    logic [DATA_W-1:0] r_ad_out, w_n_ad_out;
    logic [ADDR_W-DATA_W-1:0] r_a_hi, w_n_a_hi;
    logic r_ale, w_n_ale, r_ad_oe, w_n_ad_oe;
    logic r_m_ioN, w_n_m_ioN, r_dt_rN, w_n_dt_rN, r_bheN, w_n_bheN;
    logic r_denN, w_n_denN, r_rdN, w_n_rdN, r_wrN, w_n_wrN;
    logic r_rsp_valid, w_n_rsp_valid, r_rsp_err, w_n_rsp_err;
    logic [15:0] r_rdata, w_n_rdata;

    logic w_hold, w_timeout, w_pend, w_full, w_load;
    logic [1:0] w_rlane, w_n_lane;
    logic [15:0] w_ad16, w_wlanes;
    logic [7:0] w_rbyte, w_wbyte;

`ifdef BIU_HOLD_EN
    logic r_hlda;
    always_ff @(posedge clk) begin
        if (reset) r_hlda <= 1'b0;
        else       r_hlda <= (w_n_state == ST_TH);
    end
    assign hlda   = r_hlda;
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    generate
        if (WAIT_MAX > 0) begin : g_timer
            biu8086_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
                .clk       (clk),
                .reset     (reset),
                .i_clr     (r_state == ST_T1),
                .i_tw      (r_state == ST_TW),
                .o_timeout (w_timeout)
            );
        end else begin : g_no_timer
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_pend    = r_split && !r_second;
    assign w_full    = r_word && !r_split;
    assign req_ready = !reset && !w_hold &&
                       ((r_state == ST_TI) || ((r_state == ST_T4) && !w_pend));
    assign w_load    = req_valid && req_ready;

    assign w_ad16  = 16'(ad_in);
    assign w_rlane = lane_sel(r_addr[0], w_full, DATA_W);
    assign w_rbyte = w_rlane[1] ? w_ad16[15:8] : w_ad16[7:0];

    always_comb begin
        w_n_state     = r_state;
        w_n_addr      = r_addr;
        w_n_wdata     = r_wdata;
        w_n_wr        = r_wr;
        w_n_io        = r_io;
        w_n_word      = r_word;
        w_n_split     = r_split;
        w_n_second    = r_second;
        w_n_lo        = r_lo;
        w_n_rsp_valid = 1'b0;
        w_n_rsp_err   = 1'b0;
        w_n_rdata     = r_rdata;
        unique case (r_state)
            ST_TI: begin
                if (w_hold)      w_n_state = ST_TH;
                else if (w_load) w_n_state = ST_T1;
            end
            ST_T1: w_n_state = ST_T2;
            ST_T2: w_n_state = ST_T3;
            ST_T3, ST_TW: begin
                if (ready) begin
                    w_n_state = ST_T4;
                    if (w_pend) begin
                        w_n_lo = w_rbyte;
                    end else begin
                        w_n_rsp_valid = 1'b1;
                        if (r_wr)         w_n_rdata = 16'h0000;
                        else if (r_split) w_n_rdata = {w_rbyte, r_lo};
                        else if (w_full)  w_n_rdata = w_ad16;
                        else              w_n_rdata = {8'h00, w_rbyte};
                    end
                end else if (w_timeout) begin
                    // Abort: any outstanding split half is dropped
                    w_n_state     = ST_T4;
                    w_n_second    = 1'b1;
                    w_n_rsp_valid = 1'b1;
                    w_n_rsp_err   = 1'b1;
                    w_n_rdata     = 16'h0000;
                end else begin
                    w_n_state = ST_TW;
                end
            end
            ST_T4: begin
                if (w_pend) begin
                    w_n_state  = ST_T1;
                    w_n_addr   = r_addr + ADDR_W'(1);
                    w_n_second = 1'b1;
                end else if (w_hold) begin
                    w_n_state = ST_TH;
                end else if (w_load) begin
                    w_n_state = ST_T1;
                end else begin
                    w_n_state = ST_TI;
                end
            end
            ST_TH: begin
                if (!w_hold) w_n_state = ST_TI;
            end
            default: w_n_state = ST_TI;
        endcase
        if (w_load) begin
            w_n_addr   = req_addr;
            w_n_wdata  = req_wdata;
            w_n_wr     = req_wr;
            w_n_io     = req_io;
            w_n_word   = req_word;
            w_n_split  = split_needed(req_addr[0], req_word, DATA_W);
            w_n_second = 1'b0;
        end
    end

    assign w_n_lane = lane_sel(w_n_addr[0], w_n_word && !w_n_split, DATA_W);
    assign w_wbyte  = w_n_second ? w_n_wdata[15:8] : w_n_wdata[7:0];

    always_comb begin
        unique case (w_n_lane)
            LANE_BOTH: w_wlanes = w_n_wdata;
            LANE_HI:   w_wlanes = {w_wbyte, 8'h00};
            default:   w_wlanes = {8'h00, w_wbyte};
        endcase
    end

    always_comb begin
        w_n_ale    = 1'b0;
        w_n_ad_oe  = 1'b0;
        w_n_rdN    = 1'b1;
        w_n_wrN    = 1'b1;
        w_n_denN   = 1'b1;
        w_n_ad_out = r_ad_out;
        w_n_a_hi   = r_a_hi;
        w_n_m_ioN  = r_m_ioN;
        w_n_dt_rN  = r_dt_rN;
        w_n_bheN   = r_bheN;
        unique case (w_n_state)
            ST_T1: begin
                w_n_ale    = 1'b1;
                w_n_ad_oe  = 1'b1;
                w_n_ad_out = w_n_addr[DATA_W-1:0];
                w_n_a_hi   = w_n_addr[ADDR_W-1:DATA_W];
                w_n_m_ioN  = !w_n_io;
                w_n_dt_rN  = w_n_wr;
                w_n_bheN   = w_n_lane[1] ? BHE_ON : BHE_OFF;
            end
            ST_T2, ST_T3, ST_TW: begin
                w_n_denN = 1'b0;
                if (w_n_wr) begin
                    w_n_ad_oe  = 1'b1;
                    w_n_ad_out = w_wlanes[DATA_W-1:0];
                    w_n_wrN    = 1'b0;
                end else begin
                    w_n_rdN = 1'b0;
                end
            end
            ST_T4: ;
            default: begin
                w_n_ad_out = '0;
                w_n_a_hi   = '0;
                w_n_m_ioN  = 1'b1;
                w_n_dt_rN  = 1'b1;
                w_n_bheN   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_TI;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_io        <= 1'b0;
            r_word      <= 1'b0;
            r_split     <= 1'b0;
            r_second    <= 1'b0;
            r_lo        <= '0;
            r_ad_out    <= '0;
            r_a_hi      <= '0;
            r_ale       <= 1'b0;
            r_ad_oe     <= 1'b0;
            r_m_ioN     <= 1'b1;
            r_dt_rN     <= 1'b1;
            r_bheN      <= 1'b1;
            r_denN      <= 1'b1;
            r_rdN       <= 1'b1;
            r_wrN       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_n_state;
            r_addr      <= w_n_addr;
            r_wdata     <= w_n_wdata;
            r_wr        <= w_n_wr;
            r_io        <= w_n_io;
            r_word      <= w_n_word;
            r_split     <= w_n_split;
            r_second    <= w_n_second;
            r_lo        <= w_n_lo;
            r_ad_out    <= w_n_ad_out;
            r_a_hi      <= w_n_a_hi;
            r_ale       <= w_n_ale;
            r_ad_oe     <= w_n_ad_oe;
            r_m_ioN     <= w_n_m_ioN;
            r_dt_rN     <= w_n_dt_rN;
            r_bheN      <= w_n_bheN;
            r_denN      <= w_n_denN;
            r_rdN       <= w_n_rdN;
            r_wrN       <= w_n_wrN;
            r_rsp_valid <= w_n_rsp_valid;
            r_rsp_err   <= w_n_rsp_err;
            r_rdata     <= w_n_rdata;
        end
    end

    assign ad_out    = r_ad_out;
    assign a_hi      = r_a_hi;
    assign ale       = r_ale;
    assign ad_oe     = r_ad_oe;
    assign m_ioN     = r_m_ioN;
    assign dt_rN     = r_dt_rN;
    assign bheN      = r_bheN;
    assign denN      = r_denN;
    assign rdN       = r_rdN;
    assign wrN       = r_wrN;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_biu8086_bus.sv
// tb_biu8086_bus: directed bench for biu8086_bus; three instances
// (16-bit, 16-bit with WAIT_MAX=2, 8-bit) share one stimulus.
module tb_biu8086_bus;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [19:0] req_addr = '0;
    logic        req_wr = 1'b0;
    logic        req_io = 1'b0;
    logic        req_word = 1'b0;
    logic [15:0] req_wdata = '0;
    logic        ready = 1'b1;
    logic [15:0] ad_in = '0;
`ifdef BIU_HOLD_EN
    logic        hold = 1'b0;
    logic        a_hlda, b_hlda, c_hlda;
`endif

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_ad_oe, a_ale;
    logic        a_m_ioN, a_dt_rN, a_denN, a_rdN, a_wrN, a_bheN;
    logic [15:0] a_rsp_rdata, a_ad_out;
    logic [3:0]  a_a_hi;

    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_ad_oe, b_ale;
    logic        b_m_ioN, b_dt_rN, b_denN, b_rdN, b_wrN, b_bheN;
    logic [15:0] b_rsp_rdata, b_ad_out;
    logic [3:0]  b_a_hi;

    logic        c_req_ready, c_rsp_valid, c_rsp_err, c_ad_oe, c_ale;
    logic        c_m_ioN, c_dt_rN, c_denN, c_rdN, c_wrN, c_bheN;
    logic [15:0] c_rsp_rdata;
    logic [7:0]  c_ad_out;
    logic [11:0] c_a_hi;

    int n_checks = 0;
    int n_errors = 0;
    int a_rsp_cnt = 0;
    int snap;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_rsp_valid) a_rsp_cnt <= a_rsp_cnt + 1;
    end

    biu8086_bus #(.DATA_W(16), .ADDR_W(20), .WAIT_MAX(0)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_wr(req_wr), .req_io(req_io),
        .req_word(req_word), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .ready(ready), .ad_in(ad_in),
        .ad_out(a_ad_out), .ad_oe(a_ad_oe), .a_hi(a_a_hi),
        .ale(a_ale), .m_ioN(a_m_ioN), .dt_rN(a_dt_rN),
        .denN(a_denN), .rdN(a_rdN), .wrN(a_wrN),
`ifdef BIU_HOLD_EN
        .hold(hold), .hlda(a_hlda),
`endif
        .bheN(a_bheN)
    );

    biu8086_bus #(.DATA_W(16), .ADDR_W(20), .WAIT_MAX(2)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_wr(req_wr), .req_io(req_io),
        .req_word(req_word), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .ready(ready), .ad_in(ad_in),
        .ad_out(b_ad_out), .ad_oe(b_ad_oe), .a_hi(b_a_hi),
        .ale(b_ale), .m_ioN(b_m_ioN), .dt_rN(b_dt_rN),
        .denN(b_denN), .rdN(b_rdN), .wrN(b_wrN),
`ifdef BIU_HOLD_EN
        .hold(hold), .hlda(b_hlda),
`endif
        .bheN(b_bheN)
    );

    biu8086_bus #(.DATA_W(8), .ADDR_W(20), .WAIT_MAX(0)) u_c (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(c_req_ready),
        .req_addr(req_addr), .req_wr(req_wr), .req_io(req_io),
        .req_word(req_word), .req_wdata(req_wdata),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata),
        .rsp_err(c_rsp_err), .ready(ready), .ad_in(ad_in[7:0]),
        .ad_out(c_ad_out), .ad_oe(c_ad_oe), .a_hi(c_a_hi),
        .ale(c_ale), .m_ioN(c_m_ioN), .dt_rN(c_dt_rN),
        .denN(c_denN), .rdN(c_rdN), .wrN(c_wrN),
`ifdef BIU_HOLD_EN
        .hold(hold), .hlda(c_hlda),
`endif
        .bheN(c_bheN)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic issue(input logic [19:0] addr, input logic wr,
                         input logic io, input logic word,
                         input logic [15:0] wdata);
        req_addr  = addr;
        req_wr    = wr;
        req_io    = io;
        req_word  = word;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ready", a_req_ready, 1'b0);
        chk("rst_ale", a_ale, 1'b0);
        chk("rst_strobes", {a_rdN, a_wrN, a_denN, a_dt_rN, a_m_ioN, a_bheN}, 6'h3f);
        chk("rst_adoe", a_ad_oe, 1'b0);
        chk("rst_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, 18'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_ale", {a_ale, a_ad_oe, a_a_hi, a_ad_out}, 22'h0);
        chk("post_rst_ready", a_req_ready, 1'b1);

        // Zero-wait word read at 0x12344
        issue(20'h12344, 1'b0, 1'b0, 1'b1, 16'h0);
        tick();
        req_valid = 1'b0;
        chk("rd_t1_ale", a_ale, 1'b1);
        chk("rd_t1_adout", a_ad_out, 16'h2344);
        chk("rd_t1_ahi", a_a_hi, 4'h1);
        chk("rd_t1_ctl", {a_ad_oe, a_bheN, a_m_ioN, a_dt_rN}, 4'b1010);
        ad_in = 16'hBEEF;
        tick();
        chk("rd_t2_ale", a_ale, 1'b0);
        chk("rd_t2_ctl", {a_ad_oe, a_rdN, a_denN, a_wrN}, 4'b0001);
        tick();
        chk("rd_t3_ctl", {a_ale, a_ad_oe, a_rdN}, 3'b000);
        tick();
        chk("rd_t4_valid", {a_rsp_valid, a_rsp_err}, 2'b10);
        chk("rd_t4_data", a_rsp_rdata, 16'hBEEF);
        chk("rd_t4_ctl", {a_ad_oe, a_rdN, a_denN}, 3'b011);
        tick();
        chk("rd_after_valid", a_rsp_valid, 1'b0);

        // Split write of 0xA5C3 to odd address 0x00101
        do_reset();
        issue(20'h00101, 1'b1, 1'b0, 1'b1, 16'hA5C3);
        tick();
        req_valid = 1'b0;
        chk("wr1_t1", {a_ale, a_bheN, a_dt_rN}, 3'b101);
        chk("wr1_addr", a_ad_out, 16'h0101);
        tick();
        chk("wr1_t2_ctl", {a_ad_oe, a_wrN, a_denN, a_rdN}, 4'b1001);
        chk("wr1_lane_hi", a_ad_out >> 8, 16'h00C3);
        tick();
        tick();
        chk("wr1_t4", {a_rsp_valid, a_req_ready, a_wrN}, 3'b001);
        tick();
        chk("wr2_t1", {a_ale, a_bheN}, 2'b11);
        chk("wr2_addr", {a_a_hi, a_ad_out}, 20'h00102);
        tick();
        chk("wr2_lane_lo", a_ad_out & 16'h00FF, 16'h00A5);
        chk("wr2_t2_wrN", a_wrN, 1'b0);
        tick();
        tick();
        chk("wr2_t4", {a_rsp_valid, a_rsp_err}, 2'b10);

        // Three wait states, unlimited timer
        do_reset();
        ready = 1'b0;
        ad_in = 16'hDEAD;
        issue(20'h00200, 1'b0, 1'b0, 1'b1, 16'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ws_tw3_valid", a_rsp_valid, 1'b0);
        chk("ws_tw3_ctl", {a_ad_oe, a_rdN}, 2'b00);
        ready = 1'b1;
        ad_in = 16'h1357;
        tick();
        chk("ws_t4_valid", a_rsp_valid, 1'b1);
        chk("ws_t4_data", a_rsp_rdata, 16'h1357);

        // WAIT_MAX=2, ready stuck low
        do_reset();
        ready = 1'b0;
        ad_in = 16'h5555;
        issue(20'h00300, 1'b0, 1'b0, 1'b1, 16'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("to_tw2", {b_rsp_valid, b_rdN}, 2'b00);
        tick();
        chk("to_t4", {b_rsp_valid, b_rsp_err}, 2'b11);
        chk("to_data", b_rsp_rdata, 16'h0000);
        ready = 1'b1;

        // 8-bit bus, word read wrapping at 0xFFFFF
        do_reset();
        issue(20'hFFFFF, 1'b0, 1'b0, 1'b1, 16'h0);
        tick();
        req_valid = 1'b0;
        chk("b8_t1_addr", {c_a_hi, c_ad_out}, 20'hFFFFF);
        chk("b8_t1_bhe", c_bheN, 1'b1);
        ad_in = 16'h0011;
        tick();
        tick();
        tick();
        chk("b8_first_t4", c_rsp_valid, 1'b0);
        ad_in = 16'h0022;
        tick();
        chk("b8_wrap_addr", {c_ale, c_a_hi, c_ad_out}, 21'h100000);
        tick();
        tick();
        tick();
        chk("b8_valid", c_rsp_valid, 1'b1);
        chk("b8_data", c_rsp_rdata, 16'h2211);

        // Odd-byte IO read on the 16-bit bus
        do_reset();
        issue(20'h00105, 1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        req_valid = 1'b0;
        chk("ob_t1", {a_m_ioN, a_bheN}, 2'b00);
        ad_in = 16'hAB12;
        tick();
        tick();
        tick();
        chk("ob_valid", a_rsp_valid, 1'b1);
        chk("ob_data", a_rsp_rdata, 16'h00AB);

        // Reset pulsed in T2
        do_reset();
        issue(20'h00200, 1'b0, 1'b0, 1'b1, 16'h0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("rm_t2_rdN", a_rdN, 1'b0);
        snap = a_rsp_cnt;
        reset = 1'b1;
        tick();
        chk("rm_strobes", {a_rdN, a_denN, a_ad_oe, a_req_ready}, 4'b1100);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rm_no_rsp", a_rsp_cnt, snap);
        chk("rm_idle_ready", a_req_ready, 1'b1);

`ifdef BIU_HOLD_EN
        // HOLD raised during T2 of a split write
        do_reset();
        issue(20'h00101, 1'b1, 1'b0, 1'b1, 16'hA5C3);
        tick();
        issue(20'h00400, 1'b0, 1'b0, 1'b1, 16'h0);
        tick();
        hold = 1'b1;
        tick();
        tick();
        chk("hd_half1_t4", {a_rsp_valid, a_hlda}, 2'b00);
        tick();
        chk("hd_half2_t1", {a_ale, a_a_hi, a_ad_out}, 21'h100102);
        tick();
        tick();
        tick();
        chk("hd_half2_t4", {a_rsp_valid, a_req_ready}, 2'b10);
        tick();
        chk("hd_th", {a_hlda, a_ad_oe, a_ale, a_wrN, a_rdN}, 5'b10011);
        tick();
        chk("hd_th_ready", {a_hlda, a_req_ready}, 2'b10);
        hold = 1'b0;
        tick();
        chk("hd_release", {a_hlda, a_ale}, 2'b00);
        req_valid = 1'b0;
        tick();
        chk("hd_next_t1", {a_ale, a_ad_out}, 17'h10400);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
